// File: rtl/mmio_ctrl.sv
// MMIO controller for the MEM/WB stage: UART TX holding register, RX FIFO and
// cycle/instret counters, with load data registered to match block-RAM latency.
module mmio_ctrl #(
    parameter int RX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  we,
    input  logic        re,
    input  logic        inst_retired,
    output logic [31:0] rdata,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);
    localparam int PW = $clog2(RX_DEPTH);

    logic          sel, st, ld;
    logic [5:0]    word;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic [7:0]    mem [RX_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [PW:0]   count;
    logic          full, nonempty, push, pop;
    logic [31:0]   cyc, ins, rmux;

    assign sel      = (addr[31:28] == 4'h8);
    assign word     = addr[7:2];
    assign st       = sel && (we != 4'b0);
    assign ld       = sel && re;
    assign full     = (count == (PW+1)'(RX_DEPTH));
    assign nonempty = (count != '0);

    // Ready is forced low in reset so the UART never sees a byte accepted then.
    assign uart_rx_ready = !full && !rst;
    assign push          = uart_rx_valid && uart_rx_ready;
    assign pop           = ld && (word == 6'h01) && nonempty;

    assign uart_tx_valid = tx_valid;
    assign uart_tx_data  = tx_data;

    // Read mux reflects pre-edge state, so a same-cycle store is not visible.
    always_comb begin
        rmux = '0;
        if (sel) begin
            case (word)
                6'h00: rmux = {16'b0, 8'(count), 6'b0, nonempty, !tx_valid};
                6'h01: if (nonempty) rmux = {24'b0, mem[rptr]};
                6'h04: rmux = cyc;
                6'h05: rmux = ins;
                default: rmux = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= uart_rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata    <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            cyc      <= '0;
            ins      <= '0;
        end else begin
            if (re) rdata <= rmux;

            // A store in the handshake cycle sees tx_valid=1 and is dropped.
            if (tx_valid && uart_tx_ready) begin
                tx_valid <= 1'b0;
            end else if (!tx_valid && st && (word == 6'h02)) begin
                tx_valid <= 1'b1;
                tx_data  <= wdata[7:0];
            end

            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;

            if (st && (word == 6'h06)) begin
                cyc <= '0;
                ins <= '0;
            end else begin
                cyc <= cyc + 1'b1;
                if (inst_retired) ins <= ins + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mmio_ctrl.sv
// Scoreboarded bench for mmio_ctrl: a queue/array reference model predicts load
// data and UART handshake outputs for directed and random traffic.
module tb_mmio_ctrl;
    localparam int RX_DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata;
    logic [3:0]  we;
    logic        re, inst_retired;
    logic [31:0] rdata;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid, uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid, uart_rx_ready;

    mmio_ctrl #(.RX_DEPTH(RX_DEPTH)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .inst_retired(inst_retired), .rdata(rdata),
        .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
        .uart_tx_ready(uart_tx_ready), .uart_rx_data(uart_rx_data),
        .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        m_txv;
    logic [7:0]  m_txd;
    logic [7:0]  m_fifo[$];
    logic [31:0] m_cyc, m_ins;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int n;
        n = m_fifo.size();
        if (a[31:28] != 4'h8) return 32'h0;
        case (a[7:0] & 8'hFC)
            8'h00: return 32'(n * 256 + (n > 0 ? 2 : 0) + (m_txv ? 0 : 1));
            8'h04: return (n > 0) ? {24'h0, m_fifo[0]} : 32'h0;
            8'h10: return m_cyc;
            8'h14: return m_ins;
            default: return 32'h0;
        endcase
    endfunction

    task automatic idle();
        addr = 32'h0; wdata = 32'h0; we = 4'h0; re = 1'b0; inst_retired = 1'b0;
        uart_tx_ready = 1'b0; uart_rx_valid = 1'b0; uart_rx_data = 8'h0;
    endtask

    // Advance model by one cycle using current inputs, clock the DUT, then check
    task automatic tick();
        logic       sel, store, rxr;
        logic [7:0] off;
        sel   = (addr[31:28] == 4'h8);
        off   = addr[7:0] & 8'hFC;
        store = sel && (we != 4'h0);
        if (rst) begin
            m_txv = 1'b0; m_txd = 8'h0; m_fifo.delete(); m_cyc = 0; m_ins = 0;
        end else begin
            if (re) exp_q.push_back(m_read(addr));
            rxr = (m_fifo.size() < RX_DEPTH);
            if (re && sel && off == 8'h04 && m_fifo.size() > 0) void'(m_fifo.pop_front());
            if (uart_rx_valid && rxr) m_fifo.push_back(uart_rx_data);
            if (m_txv && uart_tx_ready) m_txv = 1'b0;
            else if (!m_txv && store && off == 8'h08) begin
                m_txv = 1'b1; m_txd = wdata[7:0];
            end
            if (store && off == 8'h18) begin
                m_cyc = 0; m_ins = 0;
            end else begin
                m_cyc = m_cyc + 1;
                if (inst_retired) m_ins = m_ins + 1;
            end
        end
        @(posedge clk);
        #1;
        check("tx_valid", 32'(uart_tx_valid), 32'(m_txv));
        if (m_txv) check("tx_data", 32'(uart_tx_data), 32'(m_txd));
        if (rst) begin
            check("rst_rdata", rdata, 32'h0);
            check("rst_tx_data", 32'(uart_tx_data), 32'h0);
        end
        check("rx_ready", 32'(uart_rx_ready), 32'(!rst && m_fifo.size() < RX_DEPTH));
    endtask

    task automatic load(input logic [31:0] a);
        idle(); addr = a; re = 1'b1; tick(); idle();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        idle(); addr = a; wdata = d; we = 4'hF; tick(); idle();
    endtask

    // Monitor: every load accepted at an edge yields rdata after that edge
    initial begin
        logic took;
        logic [31:0] e;
        forever begin
            @(posedge clk);
            took = re && !rst;
            @(negedge clk);
            if (took) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_underflow: got %h expected none", rdata);
                end else begin
                    e = exp_q.pop_front();
                    check("rdata", rdata, e);
                end
            end
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // 1: cycle counter and idle ctrl
        repeat (5) tick();
        load(32'h8000_0010);
        load(32'h8000_0000);

        // 2: TX hold, dropped second store, handshake
        store(32'h8000_0008, 32'h41);
        tick(); tick();
        store(32'h8000_0008, 32'h42);
        uart_tx_ready = 1'b1; tick(); idle();
        tick();
        load(32'h8000_0000);

        // 3: fill FIFO, 9th byte held, drain in order
        for (int i = 0; i < 9; i++) begin
            uart_rx_valid = 1'b1; uart_rx_data = 8'(8'h10 + (i < 8 ? i : 8)); tick();
        end
        idle();
        load(32'h8000_0000);
        for (int i = 0; i < 10; i++) load(32'h8000_0004);
        load(32'h8000_0000);

        // 4: simultaneous push/pop at count 3, then empty + push + load
        for (int i = 0; i < 3; i++) begin
            uart_rx_valid = 1'b1; uart_rx_data = 8'(8'h20 + i); tick();
        end
        addr = 32'h8000_0004; re = 1'b1; uart_rx_valid = 1'b1; uart_rx_data = 8'h23; tick(); idle();
        load(32'h8000_0000);
        for (int i = 0; i < 3; i++) load(32'h8000_0004);
        addr = 32'h8000_0004; re = 1'b1; uart_rx_valid = 1'b1; uart_rx_data = 8'h55; tick(); idle();
        load(32'h8000_0000);
        load(32'h8000_0004);

        // 5: instret with counter reset, load+store same cycle
        for (int i = 0; i < 10; i++) begin inst_retired = 1'b1; tick(); idle(); end
        load(32'h8000_0014);
        store(32'h8000_0018, 32'h0);
        load(32'h8000_0010);
        for (int i = 0; i < 4; i++) begin inst_retired = 1'b1; tick(); idle(); end
        load(32'h8000_0014);
        addr = 32'h8000_0014; re = 1'b1; we = 4'hF; tick(); idle();
        load(32'h8000_0014);

        // 6: reset with TX busy and FIFO count 5, then out-of-range loads
        store(32'h8000_0008, 32'h77);
        for (int i = 0; i < 5; i++) begin
            uart_rx_valid = 1'b1; uart_rx_data = 8'(8'h30 + i); tick();
        end
        idle();
        rst = 1'b1; tick(); rst = 1'b0;
        load(32'h0000_0000);
        load(32'h8000_001C);
        load(32'h8000_0000);
        load(32'h8000_0010);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            logic [7:0] offs [8];
            offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C};
            idle();
            case ($urandom_range(0, 9))
                0:       addr = 32'h0000_0000 | 32'(offs[$urandom_range(0, 7)]);
                1:       addr = 32'h9000_0000 | 32'(offs[$urandom_range(0, 7)]);
                default: addr = 32'h8000_0000 | 32'(offs[$urandom_range(0, 7)]);
            endcase
            addr[1:0]     = 2'($urandom_range(0, 3));
            wdata         = $urandom;
            re            = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0) we = 4'($urandom_range(1, 15));
            if (addr[7:0] >= 8'h18 && addr[7:0] < 8'h1C && $urandom_range(0, 3) != 0) we = 4'h0;
            inst_retired  = ($urandom_range(0, 1) == 1);
            uart_tx_ready = ($urandom_range(0, 3) == 0);
            uart_rx_valid = ($urandom_range(0, 2) == 0);
            uart_rx_data  = 8'($urandom);
            rst           = ($urandom_range(0, 149) == 0);
            tick();
            rst = 1'b0;
        end

        idle();
        repeat (3) tick();
        check("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
